// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage plus MEM/WB latch. Runs the data-memory access over a
// req/gnt/rvalid handshake, stalls upstream while it is outstanding, and drives pcsrc.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        wb_ctl_in,
    input  logic              branch_in,
    input  logic              memread_in,
    input  logic              memwrite_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [REG_W-1:0]  wr_reg_in,
    output logic              stall,
    output logic              pcsrc,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [1:0]        wb_ctl,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] alu_result,
    output logic [REG_W-1:0]  wr_reg,
    output logic              mem_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       lat_ctl;
    logic [REG_W-1:0] lat_wr_reg;
    logic             mem_op;
    logic             illegal_op;
    logic             legal_op;

    assign mem_op     = in_valid & (memread_in | memwrite_in);
    assign illegal_op = (alu_result_in[1:0] != 2'b00) | (memread_in & memwrite_in);
    assign legal_op   = mem_op & ~illegal_op;

    assign stall = (state != IDLE) | legal_op;
    assign pcsrc = branch_in & zero_in & in_valid;

    // dmem_addr/dmem_wdata/dmem_we double as the latched entry while the access is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_ctl    <= 2'b00;
            lat_wr_reg <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_ctl     <= 2'b00;
            read_data  <= '0;
            alu_result <= '0;
            wr_reg     <= '0;
            mem_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        wb_valid   <= in_valid;
                        wb_ctl     <= wb_ctl_in;
                        alu_result <= alu_result_in;
                        wr_reg     <= wr_reg_in;
                        read_data  <= '0;
                    end else if (illegal_op) begin
                        wb_valid   <= 1'b1;
                        wb_ctl     <= {1'b0, wb_ctl_in[0]};
                        alu_result <= alu_result_in;
                        wr_reg     <= wr_reg_in;
                        read_data  <= '0;
                        mem_err    <= 1'b1;
                    end else begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memwrite_in;
                        dmem_addr  <= alu_result_in;
                        dmem_wdata <= wdata_in;
                        lat_ctl    <= wb_ctl_in;
                        lat_wr_reg <= wr_reg_in;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            wb_valid   <= 1'b1;
                            wb_ctl     <= lat_ctl;
                            alu_result <= dmem_addr;
                            wr_reg     <= lat_wr_reg;
                            read_data  <= '0;
                            state      <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_valid   <= 1'b1;
                        wb_ctl     <= lat_ctl;
                        alu_result <= dmem_addr;
                        wr_reg     <= lat_wr_reg;
                        read_data  <= dmem_rdata;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized checks of mem_wb_stage against a
// transaction-level model of the MEM stage rules, with the bench acting as data memory.
`timescale 1ns/1ps
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  wb_ctl_in;
    logic        branch_in;
    logic        memread_in;
    logic        memwrite_in;
    logic        zero_in;
    logic [31:0] alu_result_in;
    logic [31:0] wdata_in;
    logic [4:0]  wr_reg_in;
    logic        stall;
    logic        pcsrc;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [1:0]  wb_ctl;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  wr_reg;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wb_ctl_in(wb_ctl_in),
        .branch_in(branch_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
        .zero_in(zero_in), .alu_result_in(alu_result_in), .wdata_in(wdata_in),
        .wr_reg_in(wr_reg_in), .stall(stall), .pcsrc(pcsrc), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ctl(wb_ctl), .read_data(read_data),
        .alu_result(alu_result), .wr_reg(wr_reg), .mem_err(mem_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one EX/MEM entry at a negedge, plays the memory side, and checks the
    // resulting MEM/WB entry; returns at the negedge after the entry reaches WB.
    task automatic applyStimulus(input logic v, input logic [1:0] ctl, input logic br, input logic z,
                                 input logic mr, input logic mw, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [4:0] wr,
                                 input int gntWait, input int rvWait, input logic [31:0] rdata);
        bit memOp;
        bit bad;
        memOp = v && (mr || mw);
        bad   = memOp && ((alu[1:0] != 2'b00) || (mr && mw));
        in_valid = v; wb_ctl_in = ctl; branch_in = br; zero_in = z;
        memread_in = mr; memwrite_in = mw; alu_result_in = alu; wdata_in = wd; wr_reg_in = wr;
        dmem_gnt = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata = 32'($urandom);
        #1;
        checkOutput("pcsrc", 32'(pcsrc), 32'(br & z & v));
        checkOutput("stall_accept", 32'(stall), 32'(memOp && !bad));
        @(negedge clk);
        if (!memOp || bad) begin
            checkOutput("wb_valid", 32'(wb_valid), 32'(memOp ? 1'b1 : v));
            checkOutput("wb_ctl", 32'(wb_ctl), 32'(bad ? {1'b0, ctl[0]} : ctl));
            checkOutput("alu_result", alu_result, alu);
            checkOutput("wr_reg", 32'(wr_reg), 32'(wr));
            checkOutput("mem_err", 32'(mem_err), 32'(bad));
            checkOutput("dmem_req_idle", 32'(dmem_req), 32'd0);
            if (!memOp) checkOutput("read_data_alu", read_data, 32'd0);
        end else begin
            for (int i = 0; i <= gntWait; i++) begin
                checkOutput("dmem_req", 32'(dmem_req), 32'd1);
                checkOutput("dmem_we", 32'(dmem_we), 32'(mw));
                checkOutput("dmem_addr", dmem_addr, alu);
                checkOutput("dmem_wdata", dmem_wdata, wd);
                checkOutput("stall_req", 32'(stall), 32'd1);
                checkOutput("wb_valid_req", 32'(wb_valid), 32'd0);
                dmem_gnt = (i == gntWait);
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata = 32'($urandom);
                @(negedge clk);
            end
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            checkOutput("dmem_req_after_gnt", 32'(dmem_req), 32'd0);
            if (!mw) begin
                for (int i = 0; i <= rvWait; i++) begin
                    checkOutput("stall_resp", 32'(stall), 32'd1);
                    checkOutput("wb_valid_resp", 32'(wb_valid), 32'd0);
                    dmem_rvalid = (i == rvWait);
                    dmem_rdata = (i == rvWait) ? rdata : 32'($urandom);
                    dmem_gnt = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                dmem_rvalid = 1'b0;
                dmem_gnt = 1'b0;
                checkOutput("read_data_load", read_data, rdata);
            end
            checkOutput("wb_valid_mem", 32'(wb_valid), 32'd1);
            checkOutput("wb_ctl_mem", 32'(wb_ctl), 32'(ctl));
            checkOutput("alu_result_mem", alu_result, alu);
            checkOutput("wr_reg_mem", 32'(wr_reg), 32'(wr));
            checkOutput("mem_err_mem", 32'(mem_err), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] addr;
        int kind;
        rst_n = 1'b0;
        in_valid = 1'b0; wb_ctl_in = 2'b00; branch_in = 1'b0; memread_in = 1'b0;
        memwrite_in = 1'b0; zero_in = 1'b0; alu_result_in = '0; wdata_in = '0; wr_reg_in = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #1;
        checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_alu_result", alu_result, 32'd0);
        checkOutput("reset_mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed steps");
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 2, 0, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd9, 0, 0, 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h42, 32'h0, 5'd3, 0, 0, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd0, 0, 0, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd0, 0, 0, 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h55, 5'd4, 0, 0, 32'h0);

        $display("[TB] random steps");
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            addr = 32'($urandom);
            if (kind == 4) addr[1:0] = 2'($urandom_range(1, 3));
            else addr[1:0] = 2'b00;
            applyStimulus(kind != 0, 2'($urandom), 1'($urandom), 1'($urandom),
                          (kind == 0) ? 1'($urandom) : (kind == 2 || kind == 4 || kind == 5),
                          (kind == 0) ? 1'($urandom) : (kind == 3 || kind == 5),
                          addr, 32'($urandom), 5'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), 32'($urandom));
        end

        $display("[TB] reset during access");
        in_valid = 1'b1; wb_ctl_in = 2'b11; branch_in = 1'b0; zero_in = 1'b0;
        memread_in = 1'b1; memwrite_in = 1'b0; alu_result_in = 32'h200; wr_reg_in = 5'd6;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        checkOutput("rst_req_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_req_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 5'd12, 0, 0, 32'h0);

        in_valid = 1'b1; memread_in = 1'b1; memwrite_in = 1'b0; alu_result_in = 32'h300;
        wb_ctl_in = 2'b11; wr_reg_in = 5'd8; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        checkOutput("rst_resp_stall_before", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        checkOutput("rst_resp_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_resp_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_resp_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE, 32'h0, 5'd21, 0, 0, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
